// File: rtl/vram_port_arbiter.sv
// VRAM port A arbiter: serialises CPU word accesses and a hardware fill engine,
// alternating grants round-robin whenever both want the port in the same cycle.
module vram_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W-1:0] fill_len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              vram_cea,
    output logic              vram_wrea,
    output logic [ADDR_W-1:0] vram_ada,
    output logic [DATA_W-1:0] vram_dina,
    input  logic [DATA_W-1:0] vram_douta
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [ADDR_W-1:0] LP_ONE = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_fill_addr;
    logic [ADDR_W-1:0] r_fill_rem;
    logic [DATA_W-1:0] r_fill_value;
    logic              r_rr_cpu_next;
    logic              r_cpu_issue;
    logic              r_cpu_issue_rd;
    logic              r_cpu_ack;
    logic              r_ack_rd;
    logic              r_fill_last;
    logic              r_fill_done;
    logic              r_cea;
    logic              r_wrea;
    logic [ADDR_W-1:0] r_ada;
    logic [DATA_W-1:0] r_dina;

    logic              w_busy;
    logic              w_fill_accept;
    logic              w_cpu_want;
    logic              w_fill_want;
    logic              w_grant_cpu;
    logic              w_grant_fill;
    logic              w_last_word;

    // The CPU may not be re-granted while its access is in flight or being acked.
    assign w_cpu_want    = cpu_req && !r_cpu_issue && !r_cpu_ack;
    assign w_fill_want   = (r_state == FILL);
    assign w_last_word   = (r_fill_rem == LP_ONE);
    assign w_fill_accept = fill_start && !w_busy;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_fill_accept && (fill_len != '0)) w_state_nxt = FILL;
            FILL:    if (w_grant_fill && w_last_word)       w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_busy       = (r_state == FILL) || r_fill_last;
        w_grant_cpu  = w_cpu_want;
        w_grant_fill = w_fill_want;
        if (w_cpu_want && w_fill_want) begin
            w_grant_cpu  = r_rr_cpu_next;
            w_grant_fill = !r_rr_cpu_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fill_addr    <= '0;
            r_fill_rem     <= '0;
            r_fill_value   <= '0;
            r_rr_cpu_next  <= 1'b1;
            r_cpu_issue    <= 1'b0;
            r_cpu_issue_rd <= 1'b0;
            r_cpu_ack      <= 1'b0;
            r_ack_rd       <= 1'b0;
            r_fill_last    <= 1'b0;
            r_fill_done    <= 1'b0;
            r_cea          <= 1'b0;
            r_wrea         <= 1'b0;
            r_ada          <= '0;
            r_dina         <= '0;
        end else begin
            r_cea          <= w_grant_cpu || w_grant_fill;
            r_wrea         <= w_grant_fill || (w_grant_cpu && cpu_we);
            if (w_grant_fill) begin
                r_ada  <= r_fill_addr;
                r_dina <= r_fill_value;
            end else if (w_grant_cpu) begin
                r_ada  <= cpu_addr;
                r_dina <= cpu_wdata;
            end

            r_cpu_issue    <= w_grant_cpu;
            r_cpu_issue_rd <= w_grant_cpu && !cpu_we;
            r_cpu_ack      <= r_cpu_issue;
            r_ack_rd       <= r_cpu_issue_rd;

            if (w_grant_cpu) begin
                r_rr_cpu_next <= 1'b0;
            end else if (w_grant_fill) begin
                r_rr_cpu_next <= 1'b1;
            end

            r_fill_last <= w_grant_fill && w_last_word;
            r_fill_done <= r_fill_last || (w_fill_accept && (fill_len == '0));

            // Address wraps naturally at the ADDR_W boundary.
            if (w_fill_accept) begin
                r_fill_addr  <= fill_base;
                r_fill_rem   <= fill_len;
                r_fill_value <= fill_value;
            end else if (w_grant_fill) begin
                r_fill_addr <= r_fill_addr + LP_ONE;
                r_fill_rem  <= r_fill_rem - LP_ONE;
            end
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = (r_cpu_ack && r_ack_rd) ? vram_douta : '0;
    assign fill_busy = w_busy;
    assign fill_done = r_fill_done;
    assign vram_cea  = r_cea;
    assign vram_wrea = r_wrea;
    assign vram_ada  = r_ada;
    assign vram_dina = r_dina;

endmodule

// File: doc/vram_port_arbiter.md
VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

Interface
REQ-001 SHALL have parameters ADDR_W, default 12, VRAM word address width; DATA_W, default 16, VRAM word width.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack is high for a read.
- fill_start  in  1  one-cycle pulse that starts a fill.
- fill_base  in  ADDR_W  first fill address.
- fill_len  in  ADDR_W  number of words to write.
- fill_value  in  DATA_W  fill word.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse when a fill completes.
- vram_cea  out  1  VRAM port A clock enable.
- vram_wrea  out  1  VRAM port A write enable.
- vram_ada  out  ADDR_W  VRAM port A address.
- vram_dina  out  DATA_W  VRAM port A write data.
- vram_douta  in  DATA_W  VRAM port A read data; valid the cycle after an access is issued (bypass read mode).

Function
REQ-003 SHALL own VRAM port A exclusively. Port B (video scanout) is outside this block.
REQ-004 SHALL issue at most one port A access per cycle. An access is issued in cycle N when vram_cea=1. vram_cea, vram_wrea, vram_ada and vram_dina SHALL all be registered.
REQ-005 SHALL implement states IDLE and FILL. IDLE -> FILL on fill_start with fill_len != 0. FILL -> IDLE after the last fill write is issued.
REQ-006 SHALL ignore fill_start while fill_busy=1. A fill_start with fill_len=0 SHALL cause no writes and SHALL pulse fill_done in the next cycle.
REQ-007 SHALL latch fill_base, fill_len and fill_value on the accepted fill_start.
REQ-008 SHALL issue fill writes at consecutive addresses starting at the latched base. The address SHALL wrap modulo 2^ADDR_W (0xFFF -> 0x000).
REQ-009 SHALL hold fill_busy=1 from the cycle after an accepted fill_start through the cycle the last fill write is issued.
REQ-010 SHALL pulse fill_done one cycle after the last fill write is issued.
REQ-011 In IDLE, SHALL grant a pending CPU request in the cycle after cpu_req is seen high.
REQ-012 In FILL, when CPU and fill both want the port, grants SHALL alternate round-robin: the CPU is granted if the previous grant went to fill, otherwise fill is granted. The CPU SHALL therefore wait at most 1 extra cycle and fill SHALL make progress at least every 2 cycles.
REQ-013 SHALL pulse cpu_ack in the cycle after the CPU access is issued. For reads, cpu_rdata SHALL equal vram_douta in that cycle.
REQ-014 SHALL NOT grant the CPU again in the cycle its cpu_ack is high, even if cpu_req is still high. A new request is sampled from the cycle after cpu_ack.
REQ-015 A fill write MAY be issued in the same cycle a prior CPU read returns data. cpu_rdata SHALL still reflect the CPU read address.
REQ-016 An access to an address already written by the fill SHALL return fill_value.

Reset
REQ-017 While resetn=0 at a clock edge, SHALL set: state IDLE, cpu_ack=0, cpu_rdata=0, fill_busy=0, fill_done=0, vram_cea=0, vram_wrea=0, vram_ada=0, vram_dina=0, round-robin pointer = CPU-next.
REQ-018 Reset during a fill SHALL abort it with no fill_done pulse. Reset during an outstanding CPU access SHALL drop it with no cpu_ack.

Verification
REQ-019 Idle CPU write 0x123 <- 0xBEEF, then read 0x123 -> each cpu_ack 2 cycles after cpu_req rises; read returns cpu_rdata=0xBEEF.
REQ-020 Fill base=0x010, len=4, value=0x5A5A -> writes to 0x010-0x013 on 4 consecutive cycles; fill_done 1 cycle after the 0x013 write; 0x014 unchanged.
REQ-021 Fill base=0xFFE, len=4 -> writes to 0xFFE, 0xFFF, 0x000, 0x001.
REQ-022 CPU read held continuously during fill len=8 -> issue pattern alternates fill/CPU; fill completes in ≤16 cycles; every CPU read returns correct data; no double-ack.
REQ-023 fill_start during busy, and fill_start with len=0 -> first is ignored (no change to latched parameters); second gives fill_done next cycle with no vram_cea.
REQ-024 resetn low for 1 cycle mid-fill (after 3 of 8 words) -> all outputs at REQ-017 values; no fill_done; next fill_start is accepted normally.
